// File: rtl/uart_crc_frame_tx.sv
// uart_crc_frame_tx
// Frame transmitter that serializes payload bytes as UART 8N1 (LSB first,
// one start bit, one stop bit). After the byte flagged with data_last, it
// appends a CRC-8 byte (poly 0x07, init 0x00, MSB-first, no reflection,
// no final XOR) to the line with no idle gap.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   data_in    in   payload byte
//   data_valid in   data_in is valid
//   data_last  in   current byte ends the frame
//   data_ready out  byte accepted this cycle when data_valid is high (registered)
//   tx_serial  out  UART line, idles high
//   tx_start   out  one-cycle pulse at the start bit of every byte, CRC included
//   tx_data    out  byte currently on the line, held until next tx_start
//   crc_value  out  CRC of the last completed frame
//   crc_ready  out  one-cycle pulse when crc_value updates
//   busy       out  high whenever the FSM is not idle
module uart_crc_frame_tx #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD_RATE    = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  input  logic       data_last,
  output logic       data_ready,
  output logic       tx_serial,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic [7:0] crc_value,
  output logic       crc_ready,
  output logic       busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       crc_run_q, crc_run_d;
  logic             crc_pending_q, crc_pending_d;
  logic             sending_crc_q, sending_crc_d;
  logic             tx_serial_q, tx_serial_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [7:0]       crc_value_q, crc_value_d;
  logic             crc_ready_q, crc_ready_d;
  logic             data_ready_q, data_ready_d;
  logic             busy_q, busy_d;

  logic accept_s;
  logic bit_done_s;
  logic crc_next_s;

  // Byte-wide CRC-8 update, polynomial x^8+x^2+x+1, MSB first.
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] din);
    logic [7:0] c;
    c = crc ^ din;
    for (int i = 0; i < 8; i++) begin
      if (c[7]) begin
        c = {c[6:0], 1'b0} ^ 8'h07;
      end else begin
        c = {c[6:0], 1'b0};
      end
    end
    return c;
  endfunction

  assign accept_s   = data_valid & data_ready_q;
  assign bit_done_s = (cnt_q == LAST_CNT);
  // CRC byte follows only once per frame: not after the CRC byte itself.
  assign crc_next_s = crc_pending_q & ~sending_crc_q;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      idx_q         <= 3'd0;
      shift_q       <= 8'h00;
      crc_run_q     <= 8'h00;
      crc_pending_q <= 1'b0;
      sending_crc_q <= 1'b0;
      tx_serial_q   <= 1'b1;
      tx_start_q    <= 1'b0;
      tx_data_q     <= 8'h00;
      crc_value_q   <= 8'h00;
      crc_ready_q   <= 1'b0;
      data_ready_q  <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shift_q       <= shift_d;
      crc_run_q     <= crc_run_d;
      crc_pending_q <= crc_pending_d;
      sending_crc_q <= sending_crc_d;
      tx_serial_q   <= tx_serial_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
      crc_value_q   <= crc_value_d;
      crc_ready_q   <= crc_ready_d;
      data_ready_q  <= data_ready_d;
      busy_q        <= busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) state_d = S_START;
        else          state_d = S_IDLE;
      end
      S_START: begin
        if (bit_done_s) state_d = S_DATA;
        else            state_d = S_START;
      end
      S_DATA: begin
        if (bit_done_s && (idx_q == 3'd7)) state_d = S_STOP;
        else                               state_d = S_DATA;
      end
      S_STOP: begin
        if (bit_done_s) state_d = crc_next_s ? S_START : S_IDLE;
        else            state_d = S_STOP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; outputs are registered one cycle ahead.
  always_comb begin
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    shift_d       = shift_q;
    crc_run_d     = crc_run_q;
    crc_pending_d = crc_pending_q;
    sending_crc_d = sending_crc_q;
    tx_serial_d   = tx_serial_q;
    tx_start_d    = 1'b0;
    tx_data_d     = tx_data_q;
    crc_value_d   = crc_value_q;
    crc_ready_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          shift_d       = data_in;
          tx_data_d     = data_in;
          tx_start_d    = 1'b1;
          tx_serial_d   = 1'b0;
          cnt_d         = '0;
          crc_run_d     = crc8_update(crc_run_q, data_in);
          crc_pending_d = data_last;
          sending_crc_d = 1'b0;
        end else begin
          tx_serial_d = 1'b1;
        end
      end
      S_START: begin
        if (bit_done_s) begin
          cnt_d       = '0;
          idx_d       = 3'd0;
          tx_serial_d = shift_q[0];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (bit_done_s) begin
          cnt_d   = '0;
          idx_d   = idx_q + 3'd1;
          shift_d = {1'b0, shift_q[7:1]};
          // After bit 7 the line goes to the stop level.
          if (idx_q == 3'd7) tx_serial_d = 1'b1;
          else               tx_serial_d = shift_q[1];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (bit_done_s) begin
          cnt_d = '0;
          if (crc_next_s) begin
            // Chain straight into the CRC byte's start bit.
            shift_d       = crc_run_q;
            tx_data_d     = crc_run_q;
            tx_start_d    = 1'b1;
            crc_value_d   = crc_run_q;
            crc_ready_d   = 1'b1;
            sending_crc_d = 1'b1;
            crc_run_d     = 8'h00;
            tx_serial_d   = 1'b0;
          end else begin
            crc_pending_d = 1'b0;
            sending_crc_d = 1'b0;
            tx_serial_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d       = '0;
        tx_serial_d = 1'b1;
      end
    endcase
  end

  // Handshake/status flags follow the next state so they line up with it.
  always_comb begin
    data_ready_d = (state_d == S_IDLE);
    busy_d       = (state_d != S_IDLE);
  end

  assign data_ready = data_ready_q;
  assign tx_serial  = tx_serial_q;
  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign crc_value  = crc_value_q;
  assign crc_ready  = crc_ready_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_crc_frame_tx.sv
// Directed testbench for uart_crc_frame_tx with CLKS_PER_BIT = 16.
module tb_uart_crc_frame_tx;

  logic       clk;
  logic       reset;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_last;
  logic       data_ready;
  logic       tx_serial;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [7:0] crc_value;
  logic       crc_ready;
  logic       busy;

  int errors = 0;
  int checks = 0;

  // Monitor counters (sampled on falling edge).
  int         crc_cnt = 0;
  int         start_cnt = 0;
  int         dbl_cnt = 0;
  logic [7:0] last_crc = 8'h00;
  logic       prev_start = 1'b0;
  logic       prev_crc = 1'b0;

  // Frame stimulus and decoded results.
  logic [7:0] pay    [0:15];
  logic [7:0] rx_b   [0:15];
  logic [7:0] rx_txd [0:15];
  logic       rx_ok  [0:15];
  int         rx_gap [0:15];
  int         ready_viol;
  int         extra_start;
  bit         to_flag;

  uart_crc_frame_tx #(
    .CLK_FREQ  (16),
    .BAUD_RATE (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_last  (data_last),
    .data_ready (data_ready),
    .tx_serial  (tx_serial),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .crc_value  (crc_value),
    .crc_ready  (crc_ready),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (crc_ready) begin
      crc_cnt  <= crc_cnt + 1;
      last_crc <= crc_value;
    end
    if (tx_start) start_cnt <= start_cnt + 1;
    if ((tx_start && prev_start) || (crc_ready && prev_crc)) dbl_cnt <= dbl_cnt + 1;
    prev_start <= tx_start;
    prev_crc   <= crc_ready;
  end

  // Drives a frame of n payload bytes from pay[] and decodes n+1 bytes off the line.
  // Returns at cycle 159 of the final (CRC) byte.
  task automatic run_frame(input int n, input bit noise);
    int         polls;
    logic [7:0] nv_data;
    logic       nv_valid;
    logic       nv_last;
    logic       samp [0:159];
    logic [7:0] b;
    to_flag     = 1'b0;
    ready_viol  = 0;
    extra_start = 0;
    data_in    = pay[0];
    data_valid = 1'b1;
    data_last  = (n == 1);
    for (int i = 0; i <= n; i++) begin
      polls = 0;
      do begin
        @(posedge clk); #1;
        polls++;
      end while (!tx_start && polls < 400);
      if (!tx_start) begin
        checks++;
        errors++;
        $display("FAIL start_timeout byte %0d: got no tx_start after %0d cycles, required a start", i, polls);
        to_flag    = 1'b1;
        data_valid = 1'b0;
        data_last  = 1'b0;
        return;
      end
      rx_gap[i] = polls - 1;
      rx_txd[i] = tx_data;
      if (i < n - 1) begin
        nv_data  = pay[i+1];
        nv_valid = 1'b1;
        nv_last  = (i + 1 == n - 1);
      end else begin
        nv_data  = 8'h00;
        nv_valid = 1'b0;
        nv_last  = 1'b0;
      end
      data_in    = nv_data;
      data_valid = nv_valid;
      data_last  = nv_last;
      samp[0] = tx_serial;
      if (data_ready) ready_viol++;
      for (int c = 1; c < 160; c++) begin
        @(posedge clk); #1;
        samp[c] = tx_serial;
        if (data_ready) ready_viol++;
        if (tx_start) extra_start++;
        if (noise && c < 159) begin
          data_valid = c[0];
          data_in    = 8'(c * 37);
          data_last  = c[1];
        end else if (noise) begin
          data_in    = nv_data;
          data_valid = nv_valid;
          data_last  = nv_last;
        end
      end
      rx_ok[i] = 1'b1;
      for (int s = 0; s < 10; s++) begin
        for (int k = 0; k < 16; k++) begin
          if (samp[16*s+k] !== samp[16*s+8]) rx_ok[i] = 1'b0;
        end
      end
      if (samp[8] !== 1'b0)   rx_ok[i] = 1'b0;
      if (samp[152] !== 1'b1) rx_ok[i] = 1'b0;
      for (int j = 0; j < 8; j++) b[j] = samp[16*(j+1)+8];
      rx_b[i] = b;
    end
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    data_in    = 8'h00;
    data_valid = 1'b0;
    data_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++; if (tx_serial !== 1'b1) begin errors++; $display("FAIL rst_tx_serial: got %b expected 1", tx_serial); end
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL rst_tx_start: got %b expected 0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data: got %h expected 00", tx_data); end
    checks++; if (crc_value !== 8'h00) begin errors++; $display("FAIL rst_crc_value: got %h expected 00", crc_value); end
    checks++; if (crc_ready !== 1'b0) begin errors++; $display("FAIL rst_crc_ready: got %b expected 0", crc_ready); end
    checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL rst_data_ready: got %b expected 1", data_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single();
    int c0;
    int s0;
    c0 = crc_cnt;
    s0 = start_cnt;
    pay[0] = 8'h01;
    run_frame(1, 1'b0);
    checks++; if (rx_b[0] !== 8'h01 || rx_ok[0] !== 1'b1) begin errors++; $display("FAIL single_byte0: got %h ok=%b expected 01 ok=1", rx_b[0], rx_ok[0]); end
    checks++; if (rx_b[1] !== 8'h07 || rx_ok[1] !== 1'b1) begin errors++; $display("FAIL single_crc_line: got %h ok=%b expected 07 ok=1", rx_b[1], rx_ok[1]); end
    checks++; if (rx_txd[1] !== 8'h07) begin errors++; $display("FAIL single_tx_data: got %h expected 07", rx_txd[1]); end
    checks++; if (rx_gap[1] !== 0) begin errors++; $display("FAIL single_start_spacing: got %0d extra cycles expected 0 (160 apart)", rx_gap[1]); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || data_ready !== 1'b1) begin errors++; $display("FAIL single_end_320: got busy=%b ready=%b expected 0/1", busy, data_ready); end
    checks++; if (crc_cnt - c0 !== 1 || last_crc !== 8'h07) begin errors++; $display("FAIL single_crc_ready: got %0d pulses value %h expected 1 pulse 07", crc_cnt - c0, last_crc); end
    checks++; if (start_cnt - s0 !== 2) begin errors++; $display("FAIL single_start_count: got %0d expected 2", start_cnt - s0); end
  endtask

  task automatic test_check_string();
    for (int i = 0; i < 9; i++) pay[i] = 8'h31 + 8'(i);
    run_frame(9, 1'b0);
    for (int i = 0; i < 9; i++) begin
      checks++; if (rx_b[i] !== pay[i] || rx_ok[i] !== 1'b1) begin errors++; $display("FAIL check_byte%0d: got %h ok=%b expected %h ok=1", i, rx_b[i], rx_ok[i], pay[i]); end
    end
    checks++; if (rx_b[9] !== 8'hF4 || rx_ok[9] !== 1'b1) begin errors++; $display("FAIL check_crc_line: got %h ok=%b expected f4 ok=1", rx_b[9], rx_ok[9]); end
    checks++; if (last_crc !== 8'hF4) begin errors++; $display("FAIL check_crc_value: got %h expected f4", last_crc); end
  endtask

  task automatic test_ignore_busy();
    int c0;
    c0 = crc_cnt;
    @(posedge clk); #1;
    pay[0] = 8'h01;
    run_frame(1, 1'b1);
    checks++; if (ready_viol !== 0) begin errors++; $display("FAIL ignore_data_ready: got %0d ready cycles expected 0", ready_viol); end
    checks++; if (rx_b[0] !== 8'h01 || rx_ok[0] !== 1'b1) begin errors++; $display("FAIL ignore_line: got %h ok=%b expected 01 ok=1", rx_b[0], rx_ok[0]); end
    checks++; if (extra_start !== 0) begin errors++; $display("FAIL ignore_extra_start: got %0d expected 0", extra_start); end
    checks++; if (crc_cnt - c0 !== 1 || last_crc !== 8'h07) begin errors++; $display("FAIL ignore_crc: got %0d pulses value %h expected 1 pulse 07", crc_cnt - c0, last_crc); end
  endtask

  task automatic test_two_frames();
    @(posedge clk); #1;
    pay[0] = 8'h01;
    run_frame(1, 1'b0);
    checks++; if (last_crc !== 8'h07) begin errors++; $display("FAIL two_frames_first: got %h expected 07", last_crc); end
    pay[0] = 8'h01;
    run_frame(1, 1'b0);
    checks++; if (last_crc !== 8'h07 || rx_b[1] !== 8'h07) begin errors++; $display("FAIL two_frames_second: got %h line %h expected 07", last_crc, rx_b[1]); end
  endtask

  task automatic test_reset_mid();
    int c0;
    int s0;
    int polls;
    @(posedge clk); #1;
    data_in    = 8'hA5;
    data_valid = 1'b1;
    data_last  = 1'b1;
    polls = 0;
    do begin
      @(posedge clk); #1;
      polls++;
    end while (!tx_start && polls < 400);
    data_valid = 1'b0;
    data_last  = 1'b0;
    checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL rmid_accept: got no tx_start expected a start"); end
    repeat (50) begin @(posedge clk); #1; end
    c0 = crc_cnt;
    s0 = start_cnt;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (tx_serial !== 1'b1 || busy !== 1'b0 || data_ready !== 1'b1) begin errors++; $display("FAIL rmid_outputs: got serial=%b busy=%b ready=%b expected 1/0/1", tx_serial, busy, data_ready); end
    checks++; if (tx_start !== 1'b0 || crc_ready !== 1'b0 || tx_data !== 8'h00 || crc_value !== 8'h00) begin errors++; $display("FAIL rmid_regs: got start=%b crcr=%b txd=%h crcv=%h expected 0/0/00/00", tx_start, crc_ready, tx_data, crc_value); end
    repeat (400) begin @(posedge clk); #1; end
    checks++; if (crc_cnt !== c0 || start_cnt !== s0) begin errors++; $display("FAIL rmid_quiet: got %0d crc pulses %0d starts expected 0/0", crc_cnt - c0, start_cnt - s0); end
    pay[0] = 8'h00;
    run_frame(1, 1'b0);
    checks++; if (rx_b[1] !== 8'h00 || last_crc !== 8'h00 || crc_cnt - c0 !== 1) begin errors++; $display("FAIL rmid_crc_cleared: got line %h value %h pulses %0d expected 00 00 1", rx_b[1], last_crc, crc_cnt - c0); end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    pay[0] = 8'h55;
    pay[1] = 8'hAA;
    run_frame(2, 1'b0);
    checks++; if (rx_b[0] !== 8'h55 || rx_b[1] !== 8'hAA) begin errors++; $display("FAIL b2b_payload: got %h %h expected 55 aa", rx_b[0], rx_b[1]); end
    checks++; if (rx_b[2] !== 8'h12 || last_crc !== 8'h12) begin errors++; $display("FAIL b2b_crc: got line %h value %h expected 12", rx_b[2], last_crc); end
    checks++; if (rx_gap[1] < 1) begin errors++; $display("FAIL b2b_idle_gap: got %0d idle cycles expected at least 1", rx_gap[1]); end
    checks++; if (rx_gap[2] !== 0) begin errors++; $display("FAIL b2b_crc_gap: got %0d idle cycles expected 0", rx_gap[2]); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_check_string();
    test_ignore_busy();
    test_two_frames();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (dbl_cnt !== 0) begin errors++; $display("FAIL pulse_width: got %0d double-cycle pulses expected 0", dbl_cnt); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
